// File: rtl/raytrace_pkg.sv
// ---------------------------------------------------------------------------
// raytrace_pkg
// Shared types for the voxel raytracer traversal stages.
//   axis_e          : axis index used for step selection and face normals
//   stepper_state_e : voxel_stepper control states
//   vox_t           : packed voxel coordinate record for the default grid
// Helper functions resolve the chooser's step mask into an axis and detect
// masks that are not exactly one-hot.
// ---------------------------------------------------------------------------
package raytrace_pkg;

    // Coordinate width of the default grid (16 voxels per axis).
    localparam int VOX_CW = 4;

    typedef enum logic [1:0] {
        AX_X = 2'd0,
        AX_Y = 2'd1,
        AX_Z = 2'd2
    } axis_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } stepper_state_e;

    typedef struct packed {
        logic [VOX_CW-1:0] x;
        logic [VOX_CW-1:0] y;
        logic [VOX_CW-1:0] z;
    } vox_t;

    // Lowest set bit wins; an empty mask falls back to x so the walk never
    // stalls on a chooser that reports nothing.
    function automatic axis_e lowest_axis(input logic [2:0] mask);
        if (mask[0])
            return AX_X;
        else if (mask[1])
            return AX_Y;
        else if (mask[2])
            return AX_Z;
        else
            return AX_X;
    endfunction

    function automatic logic is_onehot3(input logic [2:0] mask);
        return (mask == 3'b001) || (mask == 3'b010) || (mask == 3'b100);
    endfunction

endpackage

// File: rtl/voxel_stepper_if.sv
// ---------------------------------------------------------------------------
// voxel_stepper_if
// Ray-descriptor input handshake and result output handshake of the voxel
// stepper, bundled so the producer and the shading stage see one port.
//   in_*   : ray descriptor (initial voxel, step signs, tMax, tDelta)
//   res_*  : termination record (cause flags, voxel, last axis, step count)
// Modports:
//   master : ray producer / result consumer side
//   slave  : the stepper itself
// ---------------------------------------------------------------------------
interface voxel_stepper_if #(
    parameter int W  = 32,
    parameter int CW = 4,
    parameter int SW = 7
);
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_vx;
    logic [CW-1:0] in_vy;
    logic [CW-1:0] in_vz;
    logic          in_sx;
    logic          in_sy;
    logic          in_sz;
    logic [W-1:0]  in_tmax_x;
    logic [W-1:0]  in_tmax_y;
    logic [W-1:0]  in_tmax_z;
    logic [W-1:0]  in_tdelta_x;
    logic [W-1:0]  in_tdelta_y;
    logic [W-1:0]  in_tdelta_z;

    logic          res_valid;
    logic          res_ready;
    logic          res_hit;
    logic          res_oob;
    logic          res_err;
    logic [CW-1:0] res_x;
    logic [CW-1:0] res_y;
    logic [CW-1:0] res_z;
    logic [1:0]    res_axis;
    logic [SW-1:0] res_steps;

    modport master (
        output in_valid, in_vx, in_vy, in_vz, in_sx, in_sy, in_sz,
               in_tmax_x, in_tmax_y, in_tmax_z,
               in_tdelta_x, in_tdelta_y, in_tdelta_z, res_ready,
        input  in_ready, res_valid, res_hit, res_oob, res_err,
               res_x, res_y, res_z, res_axis, res_steps
    );

    modport slave (
        input  in_valid, in_vx, in_vy, in_vz, in_sx, in_sy, in_sz,
               in_tmax_x, in_tmax_y, in_tmax_z,
               in_tdelta_x, in_tdelta_y, in_tdelta_z, res_ready,
        output in_ready, res_valid, res_hit, res_oob, res_err,
               res_x, res_y, res_z, res_axis, res_steps
    );
endinterface

// File: rtl/dda_axis_lane.sv
// ---------------------------------------------------------------------------
// dda_axis_lane
// One axis of the DDA walk: holds the axis coordinate, tMax, tDelta and step
// sign for the ray in flight.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture a new ray's axis values
//   step_en    : advance this axis by one voxel
//   in_*       : axis values of the incoming ray
//   tmax       : current tMax (to the external chooser)
//   coord      : current coordinate
//   would_oob  : stepping now would leave the 0..2^CW-1 range
// ---------------------------------------------------------------------------
module dda_axis_lane #(
    parameter int W  = 32,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step_en,
    input  logic [CW-1:0] in_coord,
    input  logic          in_sign,
    input  logic [W-1:0]  in_tmax,
    input  logic [W-1:0]  in_tdelta,
    output logic [W-1:0]  tmax,
    output logic [CW-1:0] coord,
    output logic          would_oob
);

    logic          sign_r;
    logic [W-1:0]  tdelta_r;
    logic [W:0]    tmax_sum;

    // The extra carry bit tells us the add overflowed, so tMax can pin at
    // all-ones instead of wrapping back to a small (wrongly preferred) value.
    assign tmax_sum = {1'b0, tmax} + {1'b0, tdelta_r};

    // Negative rays run out at 0, positive rays at the top of the grid.
    assign would_oob = sign_r ? (coord == '0) : (coord == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            coord    <= '0;
            tmax     <= '0;
            tdelta_r <= '0;
            sign_r   <= 1'b0;
        end else if (load) begin
            coord    <= in_coord;
            tmax     <= in_tmax;
            tdelta_r <= in_tdelta;
            sign_r   <= in_sign;
        end else if (step_en) begin
            coord <= sign_r ? (coord - 1'b1) : (coord + 1'b1);
            tmax  <= tmax_sum[W] ? '1 : tmax_sum[W-1:0];
        end
    end

endmodule

// File: rtl/voxel_stepper.sv
// ---------------------------------------------------------------------------
// voxel_stepper
// Sequential DDA grid traversal: accepts one ray, then walks one voxel per
// cycle until the voxel is occupied (hit), the next step would leave the
// grid (oob), or the step budget is used up (miss).
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : ray descriptor in, termination record out
//   tmax_x/y/z        : current tMax to the external axis chooser
//   step_mask         : chooser's one-hot axis pick ([0]=x [1]=y [2]=z)
//   vox_x/y/z         : current voxel for the occupancy lookup
//   vox_valid         : vox_* is a live lookup (RUN state)
//   occ               : same-cycle occupancy of vox_*
// Build option:
//   VOXEL_STEPPER_MASKCHK_EN : a step_mask that is not one-hot ends the ray
//                              with res_err; otherwise the lowest set bit is
//                              taken and res_err stays 0.
// ---------------------------------------------------------------------------
module voxel_stepper
    import raytrace_pkg::*;
#(
    parameter int W         = 32,
    parameter int CW        = 4,
    parameter int MAX_STEPS = 64,
    parameter int SW        = $clog2(MAX_STEPS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    voxel_stepper_if.slave      bus,
    output logic [W-1:0]        tmax_x,
    output logic [W-1:0]        tmax_y,
    output logic [W-1:0]        tmax_z,
    input  logic [2:0]          step_mask,
    output logic [CW-1:0]       vox_x,
    output logic [CW-1:0]       vox_y,
    output logic [CW-1:0]       vox_z,
    output logic                vox_valid,
    input  logic                occ
);

    localparam logic [SW-1:0] STEP_LIMIT = SW'(MAX_STEPS);

    stepper_state_e state;
    logic [SW-1:0]  steps;
    axis_e          last_axis;

    logic           res_valid_r;
    logic           res_hit_r;
    logic           res_oob_r;
    logic [CW-1:0]  res_x_r;
    logic [CW-1:0]  res_y_r;
    logic [CW-1:0]  res_z_r;
    axis_e          res_axis_r;
    logic [SW-1:0]  res_steps_r;

    logic           accept;
    axis_e          sel_axis;
    logic           mask_bad;
    logic           budget_hit;
    logic           sel_oob;
    logic           advance;
    logic           oob_x;
    logic           oob_y;
    logic           oob_z;

    assign bus.in_ready = (state == ST_IDLE) && !rst;
    assign accept       = (state == ST_IDLE) && bus.in_valid;
    assign vox_valid    = (state == ST_RUN);

    assign sel_axis   = lowest_axis(step_mask);
    assign budget_hit = (steps == STEP_LIMIT);

`ifdef VOXEL_STEPPER_MASKCHK_EN
    assign mask_bad = !is_onehot3(step_mask);
`else
    assign mask_bad = 1'b0;
`endif

    // Out-of-range test follows whichever lane the chooser picked.
    always_comb begin
        sel_oob = oob_x;
        case (sel_axis)
            AX_X:    sel_oob = oob_x;
            AX_Y:    sel_oob = oob_y;
            AX_Z:    sel_oob = oob_z;
            default: sel_oob = oob_x;
        endcase
    end

    // A step happens only when none of the terminating conditions apply;
    // the lanes and the FSM both key off this one signal.
    assign advance = (state == ST_RUN) && !occ && !budget_hit && !mask_bad && !sel_oob;

    dda_axis_lane #(.W(W), .CW(CW)) u_lane_x (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step_en   (advance && (sel_axis == AX_X)),
        .in_coord  (bus.in_vx),
        .in_sign   (bus.in_sx),
        .in_tmax   (bus.in_tmax_x),
        .in_tdelta (bus.in_tdelta_x),
        .tmax      (tmax_x),
        .coord     (vox_x),
        .would_oob (oob_x)
    );

    dda_axis_lane #(.W(W), .CW(CW)) u_lane_y (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step_en   (advance && (sel_axis == AX_Y)),
        .in_coord  (bus.in_vy),
        .in_sign   (bus.in_sy),
        .in_tmax   (bus.in_tmax_y),
        .in_tdelta (bus.in_tdelta_y),
        .tmax      (tmax_y),
        .coord     (vox_y),
        .would_oob (oob_y)
    );

    dda_axis_lane #(.W(W), .CW(CW)) u_lane_z (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step_en   (advance && (sel_axis == AX_Z)),
        .in_coord  (bus.in_vz),
        .in_sign   (bus.in_sz),
        .in_tmax   (bus.in_tmax_z),
        .in_tdelta (bus.in_tdelta_z),
        .tmax      (tmax_z),
        .coord     (vox_z),
        .would_oob (oob_z)
    );

`ifdef VOXEL_STEPPER_MASKCHK_EN
    logic res_err_r;
    assign bus.res_err = res_err_r;
`else
    assign bus.res_err = 1'b0;
`endif

    // Control FSM. The result record is captured on the RUN->DONE edge and
    // held untouched until the shading stage accepts it, so backpressure
    // never disturbs the fields. Termination priority inside RUN is
    // occupancy, then budget, then bad mask, then grid exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            steps       <= '0;
            last_axis   <= AX_X;
            res_valid_r <= 1'b0;
            res_hit_r   <= 1'b0;
            res_oob_r   <= 1'b0;
            res_x_r     <= '0;
            res_y_r     <= '0;
            res_z_r     <= '0;
            res_axis_r  <= AX_X;
            res_steps_r <= '0;
`ifdef VOXEL_STEPPER_MASKCHK_EN
            res_err_r   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        state     <= ST_RUN;
                        steps     <= '0;
                        last_axis <= AX_X;
                    end
                end
                ST_RUN: begin
                    if (advance) begin
                        steps     <= steps + 1'b1;
                        last_axis <= sel_axis;
                    end else begin
                        state       <= ST_DONE;
                        res_valid_r <= 1'b1;
                        res_hit_r   <= occ;
                        res_oob_r   <= !occ && !budget_hit && !mask_bad;
                        res_x_r     <= vox_x;
                        res_y_r     <= vox_y;
                        res_z_r     <= vox_z;
                        res_axis_r  <= last_axis;
                        res_steps_r <= steps;
`ifdef VOXEL_STEPPER_MASKCHK_EN
                        res_err_r   <= !occ && !budget_hit && mask_bad;
`endif
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        state       <= ST_IDLE;
                        res_valid_r <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.res_valid = res_valid_r;
    assign bus.res_hit   = res_hit_r;
    assign bus.res_oob   = res_oob_r;
    assign bus.res_x     = res_x_r;
    assign bus.res_y     = res_y_r;
    assign bus.res_z     = res_z_r;
    assign bus.res_axis  = res_axis_r;
    assign bus.res_steps = res_steps_r;

endmodule

// File: tb/tb_voxel_stepper.sv
// ---------------------------------------------------------------------------
// tb_voxel_stepper
// Directed bench for voxel_stepper. Two instances: the default grid
// (CW=4, MAX_STEPS=64) and a small-budget one (CW=6, MAX_STEPS=8). A
// reference chooser picks the smallest tMax (lowest axis on ties), and the
// occupancy map is selected per test.
// ---------------------------------------------------------------------------
module tb_voxel_stepper;

    localparam int W    = 32;
    localparam int CW_A = 4;
    localparam int CW_B = 6;
    localparam int SW_A = 7;
    localparam int SW_B = 4;

    typedef struct packed {
        logic [7:0]  vx, vy, vz;
        logic        sx, sy, sz;
        logic [31:0] tx, ty, tz;
        logic [31:0] dx, dy, dz;
    } ray_t;

    typedef struct packed {
        logic        hit, oob, err;
        logic [7:0]  x, y, z;
        logic [1:0]  axis;
        logic [7:0]  steps;
        logic [15:0] cycle;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    voxel_stepper_if #(.W(W), .CW(CW_A), .SW(SW_A)) bus_a ();
    voxel_stepper_if #(.W(W), .CW(CW_B), .SW(SW_B)) bus_b ();

    logic [W-1:0]    tmax_x_a, tmax_y_a, tmax_z_a;
    logic [W-1:0]    tmax_x_b, tmax_y_b, tmax_z_b;
    logic [2:0]      step_mask_a, step_mask_b;
    logic [CW_A-1:0] vox_x_a, vox_y_a, vox_z_a;
    logic [CW_B-1:0] vox_x_b, vox_y_b, vox_z_b;
    logic            vox_valid_a, vox_valid_b;
    logic            occ_a, occ_b;

    logic       dut_sel     = 1'b0;
    int         occ_mode    = 0;
    logic [7:0] occ_x_match = 8'd0;
    logic       force_mask  = 1'b0;
    logic [2:0] forced_mask = 3'b000;

    logic            ob_valid, ob_hit, ob_oob, ob_err, ob_inready, ob_voxvalid;
    logic [7:0]      ob_x, ob_y, ob_z, ob_steps;
    logic [1:0]      ob_axis;
    logic [W-1:0]    ob_tmax_x;

    always #5 clk = ~clk;

    voxel_stepper #(.W(W), .CW(CW_A), .MAX_STEPS(64)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .tmax_x(tmax_x_a), .tmax_y(tmax_y_a), .tmax_z(tmax_z_a),
        .step_mask(step_mask_a),
        .vox_x(vox_x_a), .vox_y(vox_y_a), .vox_z(vox_z_a),
        .vox_valid(vox_valid_a), .occ(occ_a)
    );

    voxel_stepper #(.W(W), .CW(CW_B), .MAX_STEPS(8)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .tmax_x(tmax_x_b), .tmax_y(tmax_y_b), .tmax_z(tmax_z_b),
        .step_mask(step_mask_b),
        .vox_x(vox_x_b), .vox_y(vox_y_b), .vox_z(vox_z_b),
        .vox_valid(vox_valid_b), .occ(occ_b)
    );

    // Reference chooser: smallest tMax wins, lowest axis on ties.
    function automatic logic [2:0] chooseAxis(input logic [W-1:0] a, b, c);
        if (a <= b && a <= c)
            return 3'b001;
        else if (b <= c)
            return 3'b010;
        else
            return 3'b100;
    endfunction

    // External chooser and occupancy map, optionally overridden per test.
    always_comb begin
        step_mask_a = force_mask ? forced_mask : chooseAxis(tmax_x_a, tmax_y_a, tmax_z_a);
        step_mask_b = force_mask ? forced_mask : chooseAxis(tmax_x_b, tmax_y_b, tmax_z_b);
        occ_a = (occ_mode == 1) || ((occ_mode == 2) && (8'(vox_x_a) == occ_x_match));
        occ_b = (occ_mode == 1);
    end

    // Observation mux onto the instance under test, zero-extended to 8 bits.
    always_comb begin
        ob_valid    = dut_sel ? bus_b.res_valid : bus_a.res_valid;
        ob_hit      = dut_sel ? bus_b.res_hit   : bus_a.res_hit;
        ob_oob      = dut_sel ? bus_b.res_oob   : bus_a.res_oob;
        ob_err      = dut_sel ? bus_b.res_err   : bus_a.res_err;
        ob_inready  = dut_sel ? bus_b.in_ready  : bus_a.in_ready;
        ob_voxvalid = dut_sel ? vox_valid_b     : vox_valid_a;
        ob_x        = dut_sel ? 8'(bus_b.res_x) : 8'(bus_a.res_x);
        ob_y        = dut_sel ? 8'(bus_b.res_y) : 8'(bus_a.res_y);
        ob_z        = dut_sel ? 8'(bus_b.res_z) : 8'(bus_a.res_z);
        ob_axis     = dut_sel ? bus_b.res_axis  : bus_a.res_axis;
        ob_steps    = dut_sel ? 8'(bus_b.res_steps) : 8'(bus_a.res_steps);
        ob_tmax_x   = dut_sel ? tmax_x_b : tmax_x_a;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic ray_t mkRay(input logic [7:0] vx, vy, vz, input logic sx, sy, sz,
                                   input logic [31:0] tx, ty, tz, dx, dy, dz);
        ray_t r;
        r.vx = vx; r.vy = vy; r.vz = vz;
        r.sx = sx; r.sy = sy; r.sz = sz;
        r.tx = tx; r.ty = ty; r.tz = tz;
        r.dx = dx; r.dy = dy; r.dz = dz;
        return r;
    endfunction

    function automatic exp_t mkExp(input logic hit, oob, err, input logic [7:0] x, y, z,
                                   input logic [1:0] axis, input logic [7:0] steps,
                                   input logic [15:0] cycle);
        exp_t e;
        e.hit = hit; e.oob = oob; e.err = err;
        e.x = x; e.y = y; e.z = z;
        e.axis = axis; e.steps = steps; e.cycle = cycle;
        return e;
    endfunction

    // Both instances see the same descriptor; only in_valid selects one.
    task automatic driveRay(input ray_t r);
        bus_a.in_vx = r.vx[CW_A-1:0]; bus_a.in_vy = r.vy[CW_A-1:0]; bus_a.in_vz = r.vz[CW_A-1:0];
        bus_b.in_vx = r.vx[CW_B-1:0]; bus_b.in_vy = r.vy[CW_B-1:0]; bus_b.in_vz = r.vz[CW_B-1:0];
        bus_a.in_sx = r.sx; bus_a.in_sy = r.sy; bus_a.in_sz = r.sz;
        bus_b.in_sx = r.sx; bus_b.in_sy = r.sy; bus_b.in_sz = r.sz;
        bus_a.in_tmax_x = r.tx; bus_a.in_tmax_y = r.ty; bus_a.in_tmax_z = r.tz;
        bus_b.in_tmax_x = r.tx; bus_b.in_tmax_y = r.ty; bus_b.in_tmax_z = r.tz;
        bus_a.in_tdelta_x = r.dx; bus_a.in_tdelta_y = r.dy; bus_a.in_tdelta_z = r.dz;
        bus_b.in_tdelta_x = r.dx; bus_b.in_tdelta_y = r.dy; bus_b.in_tdelta_z = r.dz;
    endtask

    // Launch one ray, time its result, check the record, optionally hold it
    // under backpressure, then accept it and confirm the stepper is free.
    task automatic applyStimulus(input string name, input logic sel, input ray_t r,
                                 input exp_t e, input int hold);
        int   cyc;
        logic seen;
        @(negedge clk);
        dut_sel = sel;
        driveRay(r);
        bus_a.in_valid = !sel;
        bus_b.in_valid = sel;
        #1;
        checkOutput({name, "/in_ready_idle"}, ob_inready, 1);
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 300) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 2)
                checkOutput({name, "/in_ready_busy"}, ob_inready, 0);
            if (ob_valid)
                seen = 1'b1;
        end
        checkOutput({name, "/res_valid"}, seen, 1);
        checkOutput({name, "/cycle"}, cyc, e.cycle);
        checkOutput({name, "/hit"}, ob_hit, e.hit);
        checkOutput({name, "/oob"}, ob_oob, e.oob);
        checkOutput({name, "/err"}, ob_err, e.err);
        checkOutput({name, "/x"}, ob_x, e.x);
        checkOutput({name, "/y"}, ob_y, e.y);
        checkOutput({name, "/z"}, ob_z, e.z);
        checkOutput({name, "/axis"}, ob_axis, e.axis);
        checkOutput({name, "/steps"}, ob_steps, e.steps);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput({name, "/held_valid"}, ob_valid, 1);
            checkOutput({name, "/held_steps"}, ob_steps, e.steps);
            checkOutput({name, "/held_x"}, ob_x, e.x);
            checkOutput({name, "/held_hit"}, ob_hit, e.hit);
        end
        bus_a.res_ready = 1'b1;
        bus_b.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_a.res_ready = 1'b0;
        bus_b.res_ready = 1'b0;
        @(negedge clk);
        checkOutput({name, "/released_valid"}, ob_valid, 0);
        checkOutput({name, "/in_ready_after"}, ob_inready, 1);
    endtask

    // Main directed sequence.
    initial begin
        exp_t exp_mask;
        logic saw_valid;

        bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0;
        bus_a.res_ready = 1'b0; bus_b.res_ready = 1'b0;
        driveRay(mkRay(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset/in_ready", ob_inready, 0);
        checkOutput("reset/res_valid", ob_valid, 0);
        checkOutput("reset/vox_valid", ob_voxvalid, 0);
        checkOutput("reset/tmax_x", ob_tmax_x, 0);
        checkOutput("reset/res_steps", ob_steps, 0);
        rst = 1'b0;
        #1;
        checkOutput("reset/in_ready_release", ob_inready, 1);

        $display("[TB] occupied start voxel");
        occ_mode = 1;
        applyStimulus("occ_start", 1'b0, mkRay(2, 2, 2, 0, 0, 0, 10, 10, 10, 1, 1, 1),
                      mkExp(1, 0, 0, 2, 2, 2, 0, 0, 2), 0);

        $display("[TB] +x ray with backpressure");
        occ_mode = 2; occ_x_match = 8'd5;
        applyStimulus("plus_x", 1'b0, mkRay(2, 2, 2, 0, 0, 0, 1, 100, 100, 2, 50, 50),
                      mkExp(1, 0, 0, 5, 2, 2, 0, 3, 5), 5);

        $display("[TB] -y ray leaving the grid");
        occ_mode = 0;
        applyStimulus("minus_y_oob", 1'b0, mkRay(3, 1, 3, 0, 1, 0, 100, 1, 100, 50, 10, 50),
                      mkExp(0, 1, 0, 3, 0, 3, 1, 1, 3), 0);

        $display("[TB] tMax saturation and upper grid edge");
        applyStimulus("saturate", 1'b0,
                      mkRay(0, 0, 0, 0, 0, 0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h100, 1, 1),
                      mkExp(0, 1, 0, 15, 0, 0, 0, 15, 17), 0);
        checkOutput("saturate/tmax_x", ob_tmax_x, 32'hFFFF_FFFF);

        $display("[TB] step budget on the small-budget instance");
        applyStimulus("budget", 1'b1, mkRay(0, 0, 0, 0, 0, 0, 100, 100, 1, 100, 100, 1),
                      mkExp(0, 0, 0, 0, 0, 8, 2, 8, 10), 0);

        $display("[TB] forced step masks");
`ifdef VOXEL_STEPPER_MASKCHK_EN
        exp_mask = mkExp(0, 0, 1, 2, 2, 2, 0, 0, 2);
`else
        exp_mask = mkExp(1, 0, 0, 5, 2, 2, 0, 3, 5);
`endif
        occ_mode = 2; occ_x_match = 8'd5;
        force_mask = 1'b1; forced_mask = 3'b011;
        applyStimulus("mask_011", 1'b0, mkRay(2, 2, 2, 0, 0, 0, 10, 10, 10, 1, 1, 1), exp_mask, 0);
        forced_mask = 3'b000;
        applyStimulus("mask_000", 1'b0, mkRay(2, 2, 2, 0, 0, 0, 10, 10, 10, 1, 1, 1), exp_mask, 0);
        force_mask = 1'b0;

        $display("[TB] reset during RUN");
        occ_mode = 0;
        @(negedge clk);
        dut_sel = 1'b0;
        driveRay(mkRay(0, 0, 0, 0, 0, 0, 1, 100, 100, 1, 100, 100));
        bus_a.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_run/vox_valid_before", ob_voxvalid, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_run/in_ready_in_rst", ob_inready, 0);
        checkOutput("rst_run/vox_valid", ob_voxvalid, 0);
        checkOutput("rst_run/tmax_x", ob_tmax_x, 0);
        rst = 1'b0;
        #1;
        checkOutput("rst_run/in_ready_after", ob_inready, 1);
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ob_valid)
                saw_valid = 1'b1;
        end
        checkOutput("rst_run/no_result", saw_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
